ieeedrv_sd_arb: RTL and testbench



---
 rtl/ieeedrv_sd_arb.sv | 149 ++++++++++++++
 tb/tb_ieeedrv_sd_arb.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieeedrv_sd_arb.sv
// ieeedrv_sd_arb: round-robin merge of per-subdrive SD block requests onto one host SD interface
module ieeedrv_sd_arb #(
  parameter int SUBDRV    = 2,
  parameter int TIMEOUT_W = 24
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [SUBDRV-1:0]      img_mounted,
  input  logic [32*SUBDRV-1:0]   drv_lba,
  input  logic [6*SUBDRV-1:0]    drv_blk_cnt,
  input  logic [SUBDRV-1:0]      drv_rd,
  input  logic [SUBDRV-1:0]      drv_wr,
  output logic [SUBDRV-1:0]      drv_ack,
  input  logic [8*SUBDRV-1:0]    drv_buff_din,
  output logic [31:0]            sd_lba,
  output logic [5:0]             sd_blk_cnt,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  output logic [7:0]             sd_buff_din,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic                   timeout
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  localparam logic [TIMEOUT_W-1:0] TC = ~TIMEOUT_W'(1);
  state_t                 state_q;
  logic [SUBDRV-1:0]      rd_prev_q, wr_prev_q, pend_rd_q, pend_wr_q;
  logic [SUBDRV-1:0]      pend_rd_d, pend_wr_d, clr_rd, clr_wr, sel;
  logic [1:0]             grant_q, ptr_q, pick;
  logic [TIMEOUT_W-1:0]   cnt_q;
  logic [31:0]            sd_lba_q;
  logic [5:0]             sd_blk_cnt_q;
  logic                   sd_rd_q, sd_wr_q, timeout_q, found, tc, active;
  logic [2:0]             sum;
  logic [3:0]             pend4, wr4, mnt4, sel4;
  logic [31:0]            lba_a [4];
  logic [5:0]             blk_a [4];
  logic [7:0]             din_a [4];
  // Pad the per-drive buses out to four entries so every index is 2 bits wide
  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < SUBDRV) begin : g_on
      assign pend4[g] = pend_rd_q[g] | pend_wr_q[g];
      assign wr4[g]   = pend_wr_q[g];
      assign mnt4[g]  = img_mounted[g];
      assign lba_a[g] = drv_lba[32*g +: 32];
      assign blk_a[g] = drv_blk_cnt[6*g +: 6];
      assign din_a[g] = drv_buff_din[8*g +: 8];
      assign drv_ack[g] = sd_ack & active & (grant_q == 2'(g));
    end else begin : g_off
      assign pend4[g] = 1'b0;
      assign wr4[g]   = 1'b0;
      assign mnt4[g]  = 1'b0;
      assign lba_a[g] = '0;
      assign blk_a[g] = '0;
      assign din_a[g] = '0;
    end
  end
  assign active      = (state_q == REQ) || (state_q == XFER);
  assign tc          = cnt_q == TC;
  assign sel4        = 4'b0001 << grant_q;
  assign sel         = sel4[SUBDRV-1:0];
  assign sd_buff_din = din_a[grant_q];
  assign sd_lba      = sd_lba_q;
  assign sd_blk_cnt  = sd_blk_cnt_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign grant       = grant_q;
  assign busy        = state_q != IDLE;
  assign timeout     = timeout_q;
  // Pending bits: rising edges set, served/dropped grant clears, set beats clear, remount beats all
  always_comb begin
    clr_rd    = (state_q == REQ && (sd_ack || tc) && !sd_wr_q) ? sel : '0;
    clr_wr    = (state_q == REQ && (sd_ack || tc) && sd_wr_q) ? sel : '0;
    pend_rd_d = ((pend_rd_q & ~clr_rd) | (drv_rd & ~rd_prev_q)) & ~img_mounted;
    pend_wr_d = ((pend_wr_q & ~clr_wr) | (drv_wr & ~wr_prev_q)) & ~img_mounted;
  end
  // Round-robin scan from the pointer; iterating downward leaves the nearest pending drive in pick
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    sum   = '0;
    for (int j = SUBDRV - 1; j >= 0; j--) begin
      sum = {1'b0, ptr_q} + 3'(j);
      sum = (sum >= 3'(SUBDRV)) ? sum - 3'(SUBDRV) : sum;
      if (pend4[sum[1:0]]) begin
        found = 1'b1;
        pick  = sum[1:0];
      end
    end
  end
  // Arbitration FSM with registered host-side outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_prev_q    <= '0;
      wr_prev_q    <= '0;
      pend_rd_q    <= '0;
      pend_wr_q    <= '0;
      grant_q      <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      sd_lba_q     <= '0;
      sd_blk_cnt_q <= '0;
      sd_rd_q      <= 1'b0;
      sd_wr_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      rd_prev_q <= drv_rd;
      wr_prev_q <= drv_wr;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (found) begin
          state_q      <= REQ;
          grant_q      <= pick;
          sd_lba_q     <= lba_a[pick];
          sd_blk_cnt_q <= blk_a[pick];
          sd_wr_q      <= wr4[pick];
          sd_rd_q      <= !wr4[pick];
          cnt_q        <= '0;
        end
        REQ: if (sd_ack) begin
          sd_rd_q <= 1'b0;
          sd_wr_q <= 1'b0;
          state_q <= XFER;
        end else if (mnt4[grant_q]) begin
          sd_rd_q <= 1'b0;
          sd_wr_q <= 1'b0;
          state_q <= DONE;
        end else if (tc) begin
          sd_rd_q   <= 1'b0;
          sd_wr_q   <= 1'b0;
          timeout_q <= 1'b1;
          state_q   <= DONE;
        end else begin
          cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
        XFER: if (!sd_ack) state_q <= DONE;
        DONE: begin
          ptr_q   <= (grant_q == 2'(SUBDRV - 1)) ? 2'd0 : grant_q + 2'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// tb_ieeedrv_sd_arb: directed self-checking bench for the SD request arbiter
module tb_ieeedrv_sd_arb;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  img_mounted = '0;
  logic [63:0] drv_lba = '0;
  logic [11:0] drv_blk_cnt = '0;
  logic [1:0]  drv_rd = '0;
  logic [1:0]  drv_wr = '0;
  logic [1:0]  drv_ack;
  logic [15:0] drv_buff_din = 16'hB1A0;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_buff_din;
  logic [1:0]  grant;
  logic        busy, timeout;
  int checks = 0;
  int errors = 0;

  ieeedrv_sd_arb #(.SUBDRV(2), .TIMEOUT_W(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted),
    .drv_lba(drv_lba), .drv_blk_cnt(drv_blk_cnt), .drv_rd(drv_rd), .drv_wr(drv_wr),
    .drv_ack(drv_ack), .drv_buff_din(drv_buff_din), .sd_lba(sd_lba),
    .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_din(sd_buff_din), .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic finish_xfer;
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if ({sd_rd, sd_wr, drv_ack, busy, timeout, grant} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000000", {sd_rd, sd_wr, drv_ack, busy, timeout, grant});
    end
    checks++;
    if ({sd_lba, sd_blk_cnt} !== 38'h0) begin
      errors++;
      $display("FAIL reset_addr got %h/%h required 0/0", sd_lba, sd_blk_cnt);
    end
  endtask

  task automatic test_single_read;
    apply_reset();
    drv_lba[31:0] = 32'd357;
    drv_blk_cnt[5:0] = 6'd3;
    drv_rd = 2'b01;
    tick();
    checks++;
    if (sd_rd !== 1'b0) begin errors++; $display("FAIL rd_early got %b required 0", sd_rd); end
    tick();
    checks++;
    if ({sd_rd, sd_wr, busy, grant} !== 5'b10100) begin
      errors++;
      $display("FAIL rd_req got %b required 10100", {sd_rd, sd_wr, busy, grant});
    end
    checks++;
    if (sd_lba !== 32'd357 || sd_blk_cnt !== 6'd3) begin
      errors++;
      $display("FAIL rd_addr got %0d/%0d required 357/3", sd_lba, sd_blk_cnt);
    end
    sd_ack = 1'b1;
    #1;
    checks++;
    if (drv_ack !== 2'b01 || sd_buff_din !== 8'hA0) begin
      errors++;
      $display("FAIL rd_ack0 got %b/%h required 01/a0", drv_ack, sd_buff_din);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (drv_ack !== 2'b01 || sd_rd !== 1'b0) begin
        errors++;
        $display("FAIL rd_ack_hold%0d got %b/%b required 01/0", i, drv_ack, sd_rd);
      end
    end
    sd_ack = 1'b0;
    #1;
    checks++;
    if (drv_ack !== 2'b00) begin errors++; $display("FAIL rd_ack_fall got %b required 00", drv_ack); end
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rd_done_busy got %b required 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle_busy got %b required 0", busy); end
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0) begin
      errors++;
      $display("FAIL rd_level_held got %b/%b required 0/0", busy, sd_rd);
    end
    drv_rd = 2'b00;
    tick();
  endtask

  task automatic test_round_robin;
    apply_reset();
    drv_lba = {32'd200, 32'd100};
    drv_rd = 2'b11;
    tick();
    tick();
    checks++;
    if (grant !== 2'd0 || sd_rd !== 1'b1 || sd_lba !== 32'd100) begin
      errors++;
      $display("FAIL rr_first got %0d/%b/%0d required 0/1/100", grant, sd_rd, sd_lba);
    end
    sd_ack = 1'b1;
    tick();
    drv_rd = 2'b10;
    tick();
    drv_rd = 2'b11;
    tick();
    sd_ack = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 2'd1 || sd_rd !== 1'b1 || sd_lba !== 32'd200) begin
      errors++;
      $display("FAIL rr_second got %0d/%b/%0d required 1/1/200", grant, sd_rd, sd_lba);
    end
    sd_ack = 1'b1;
    #1;
    checks++;
    if (drv_ack !== 2'b10 || sd_buff_din !== 8'hB1) begin
      errors++;
      $display("FAIL rr_route got %b/%h required 10/b1", drv_ack, sd_buff_din);
    end
    tick();
    sd_ack = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 2'd0 || sd_rd !== 1'b1 || sd_lba !== 32'd100) begin
      errors++;
      $display("FAIL rr_third got %0d/%b/%0d required 0/1/100", grant, sd_rd, sd_lba);
    end
    finish_xfer();
    drv_rd = 2'b00;
    tick();
  endtask

  task automatic test_write_priority;
    apply_reset();
    drv_lba[63:32] = 32'd1102;
    drv_rd = 2'b10;
    drv_wr = 2'b10;
    tick();
    tick();
    checks++;
    if ({sd_wr, sd_rd, grant} !== 4'b1001 || sd_lba !== 32'd1102) begin
      errors++;
      $display("FAIL wp_write got %b/%0d required 1001/1102", {sd_wr, sd_rd, grant}, sd_lba);
    end
    finish_xfer();
    tick();
    checks++;
    if ({sd_wr, sd_rd, grant} !== 4'b0101 || sd_lba !== 32'd1102) begin
      errors++;
      $display("FAIL wp_read got %b/%0d required 0101/1102", {sd_wr, sd_rd, grant}, sd_lba);
    end
    finish_xfer();
    drv_rd = 2'b00;
    drv_wr = 2'b00;
    tick();
  endtask

  task automatic test_remount;
    apply_reset();
    drv_lba[31:0] = 32'd357;
    drv_rd = 2'b01;
    tick();
    tick();
    img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00;
    checks++;
    if ({sd_rd, drv_ack, busy, timeout} !== 5'b00010) begin
      errors++;
      $display("FAIL mnt_req got %b required 00010", {sd_rd, drv_ack, busy, timeout});
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0) begin
      errors++;
      $display("FAIL mnt_idle got %b/%b required 0/0", busy, sd_rd);
    end
    drv_rd = 2'b00;
    tick();
    drv_rd = 2'b01;
    tick();
    tick();
    sd_ack = 1'b1;
    tick();
    img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00;
    checks++;
    if (busy !== 1'b1 || drv_ack !== 2'b01) begin
      errors++;
      $display("FAIL mnt_xfer got %b/%b required 1/01", busy, drv_ack);
    end
    sd_ack = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mnt_done got %b required 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mnt_end got %b required 0", busy); end
    drv_rd = 2'b00;
    tick();
  endtask

  task automatic test_timeout;
    apply_reset();
    drv_rd = 2'b01;
    tick();
    tick();
    for (int i = 1; i < 15; i++) begin
      tick();
      checks++;
      if (sd_rd !== 1'b1 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_wait%0d got %b/%b required 1/0", i, sd_rd, timeout);
      end
    end
    tick();
    checks++;
    if ({sd_rd, timeout, busy} !== 3'b011) begin
      errors++;
      $display("FAIL to_fire got %b required 011", {sd_rd, timeout, busy});
    end
    tick();
    checks++;
    if ({timeout, busy} !== 2'b00) begin
      errors++;
      $display("FAIL to_pulse got %b required 00", {timeout, busy});
    end
    tick();
    tick();
    checks++;
    if ({sd_rd, busy} !== 2'b00) begin
      errors++;
      $display("FAIL to_cleared got %b required 00", {sd_rd, busy});
    end
    drv_rd = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_xfer;
    drv_lba[63:32] = 32'h55;
    drv_rd = 2'b10;
    tick();
    tick();
    sd_ack = 1'b1;
    tick();
    checks++;
    if (drv_ack !== 2'b10 || grant !== 2'd1) begin
      errors++;
      $display("FAIL rst_pre got %b/%0d required 10/1", drv_ack, grant);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({sd_rd, sd_wr, drv_ack, busy, timeout, grant} !== 8'h00 || {sd_lba, sd_blk_cnt} !== 38'h0) begin
      errors++;
      $display("FAIL rst_async got %b/%h required 00000000/0", {sd_rd, sd_wr, drv_ack, busy, timeout, grant}, sd_lba);
    end
    sd_ack = 1'b0;
    drv_rd = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    drv_rd = 2'b01;
    drv_lba[31:0] = 32'd77;
    tick();
    tick();
    checks++;
    if (sd_rd !== 1'b1 || grant !== 2'd0 || sd_lba !== 32'd77) begin
      errors++;
      $display("FAIL rst_after got %b/%0d/%0d required 1/0/77", sd_rd, grant, sd_lba);
    end
    finish_xfer();
    drv_rd = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_remount();
    test_timeout();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
